// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered display data,
// per-slot anti-ghosting blanking and leading-zero suppression.
module seg_scan_ctrl #(
    parameter int NUM_DIG = 6,
    parameter int DIV     = 50000,
    parameter int GUARD   = 500
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   load,
    input  logic [4*NUM_DIG-1:0]   digits_in,
    input  logic [NUM_DIG-1:0]     dp_in,
    input  logic                   blank_lz,
    output logic [3:0]             led_code,
    output logic [NUM_DIG-1:0]     dig_sel_n,
    output logic                   dp_n,
    output logic                   frame_done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [PW-1:0]          presc, nxt_presc;
    logic [IW-1:0]          idx, nxt_idx;
    logic [0:0]             st, nxt_st;
    logic [4*NUM_DIG-1:0]   shadow_dig, act_dig, nxt_act_dig;
    logic [NUM_DIG-1:0]     shadow_dp, act_dp, nxt_act_dp;
    logic                   pending;
    logic                   slot_end, frame_end, xfer;

    logic [NUM_DIG-1:0]     lz;
    logic [3:0]             cur_code;
    logic                   cur_dp, cur_lz, lit;
    logic [NUM_DIG-1:0]     nxt_sel;

    assign slot_end  = (presc == PW'(DIV - 1));
    assign frame_end = en && slot_end && (idx == IW'(NUM_DIG - 1));
    assign xfer      = frame_end && pending;

    always_comb begin
        nxt_presc = '0;
        nxt_st    = ST_BLANK;
        nxt_idx   = idx;
        if (en) begin
            if (slot_end) begin
                nxt_idx = (idx == IW'(NUM_DIG - 1)) ? '0 : idx + IW'(1);
            end else begin
                nxt_presc = presc + PW'(1);
                nxt_st    = (presc == PW'(GUARD - 1)) ? ST_SHOW : st;
            end
        end
    end

    assign nxt_act_dig = xfer ? shadow_dig : act_dig;
    assign nxt_act_dp  = xfer ? shadow_dp  : act_dp;

    // Outputs are registered from next-state values so they line up with the
    // state they describe instead of lagging it by a cycle.
    always_comb begin : lz_chain
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int i = NUM_DIG - 1; i >= 1; i--) begin
            lz[i] = blank_lz && run && (nxt_act_dig[4*i +: 4] == 4'd0) && !nxt_act_dp[i];
            run   = lz[i];
        end
    end

    always_comb begin
        cur_code = 4'hF;
        cur_dp   = 1'b0;
        cur_lz   = 1'b0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (nxt_idx == IW'(i)) begin
                cur_code = nxt_act_dig[4*i +: 4];
                cur_dp   = nxt_act_dp[i];
                cur_lz   = lz[i];
            end
        end
        lit = (nxt_st == ST_SHOW) && !cur_lz;
        for (int i = 0; i < NUM_DIG; i++) begin
            nxt_sel[i] = !(lit && (nxt_idx == IW'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            st         <= ST_BLANK;
            shadow_dig <= '0;
            shadow_dp  <= '0;
            act_dig    <= '0;
            act_dp     <= '0;
            pending    <= 1'b0;
            dig_sel_n  <= '1;
            led_code   <= 4'hF;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            presc   <= nxt_presc;
            idx     <= nxt_idx;
            st      <= nxt_st;
            act_dig <= nxt_act_dig;
            act_dp  <= nxt_act_dp;
            // A load on the boundary edge keeps pending set for its own data.
            if (load) begin
                shadow_dig <= digits_in;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end else if (xfer) begin
                pending    <= 1'b0;
            end
            dig_sel_n  <= nxt_sel;
            led_code   <= lit ? cur_code : 4'hF;
            dp_n       <= lit ? !cur_dp : 1'b1;
            frame_done <= xfer;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: table-driven cycle checks plus
// hand-written sequences for boundary loads, enable gaps and async reset.
module tb_seg_scan_ctrl;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [3:0]    dp_in = '0;
    logic          blank_lz = 1'b0;
    logic [3:0]    led_code;
    logic [3:0]    dig_sel_n;
    logic          dp_n;
    logic          frame_done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int         n;
        logic [3:0] sel;
        logic [3:0] code;
        logic       dp;
        logic       fd;
        string      name;
    } vec_t;

    vec_t tab[$];

    seg_scan_ctrl #(.NUM_DIG(ND), .DIV(8), .GUARD(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .led_code(led_code), .dig_sel_n(dig_sel_n), .dp_n(dp_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string name, input logic [3:0] sel, input logic [3:0] code,
                       input logic dp, input logic fd);
        n_chk++;
        if ({dig_sel_n, led_code, dp_n, frame_done} !== {sel, code, dp, fd}) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got sel=%b code=%h dp_n=%b fd=%b, want sel=%b code=%h dp_n=%b fd=%b",
                     name, cyc, dig_sel_n, led_code, dp_n, frame_done, sel, code, dp, fd);
        end
    endtask

    task automatic add(input int n, input logic [3:0] sel, input logic [3:0] code,
                       input logic dp, input logic fd, input string name);
        vec_t v;
        v.n = n; v.sel = sel; v.code = code; v.dp = dp; v.fd = fd; v.name = name;
        tab.push_back(v);
    endtask

    task automatic run_table();
        foreach (tab[k]) begin
            run_to(tab[k].n);
            chk(tab[k].name, tab[k].sel, tab[k].code, tab[k].dp, tab[k].fd);
        end
        tab.delete();
    endtask

    // Holds reset for two edges, checks reset outputs, then releases with en=1.
    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_vals", 4'hF, 4'hF, 1'b1, 1'b0);
        rst_n = 1'b1;
        en = 1'b1;
        cyc = 0;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
        digits_in = d; dp_in = dp; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] sel;

        // Scenario 1: plain scan; sample after edge n has presc = n%8, idx = (n/8)%4.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            sel = 4'hF;
            sel[k % 4] = 1'b0;
            add(8*k + 1, 4'hF, 4'hF, 1'b1, 1'b0, "s1_blank_first");
            add(8*k + 2, sel,  4'h0, 1'b1, 1'b0, "s1_lit_first");
            add(8*k + 7, sel,  4'h0, 1'b1, 1'b0, "s1_lit_last");
            add(8*k + 8, 4'hF, 4'hF, 1'b1, (k == 3) ? 1'b0 : 1'b0, "s1_blank_next");
        end
        run_table();

        // Scenario 2: mid-frame load waits for the boundary at edge 32.
        do_reset();
        run_to(10);
        do_load(16'h1234, 4'b0000);
        add(18, 4'b1011, 4'h0, 1'b1, 1'b0, "s2_no_tear_d2");
        add(26, 4'b0111, 4'h0, 1'b1, 1'b0, "s2_no_tear_d3");
        add(32, 4'hF,    4'hF, 1'b1, 1'b1, "s2_frame_done");
        add(33, 4'hF,    4'hF, 1'b1, 1'b0, "s2_fd_one_cycle");
        add(34, 4'b1110, 4'h4, 1'b1, 1'b0, "s2_d0");
        add(42, 4'b1101, 4'h3, 1'b1, 1'b0, "s2_d1");
        add(50, 4'b1011, 4'h2, 1'b1, 1'b0, "s2_d2");
        add(58, 4'b0111, 4'h1, 1'b1, 1'b0, "s2_d3");
        add(64, 4'hF,    4'hF, 1'b1, 1'b0, "s2_no_second_fd");
        run_table();

        // Scenario 3: leading-zero blanking, then a dp on digit 3 stops it.
        do_reset();
        blank_lz = 1'b1;
        do_load(16'h0012, 4'b0000);
        add(32, 4'hF,    4'hF, 1'b1, 1'b1, "s3_fd");
        add(34, 4'b1110, 4'h2, 1'b1, 1'b0, "s3_d0");
        add(42, 4'b1101, 4'h1, 1'b1, 1'b0, "s3_d1");
        add(50, 4'hF,    4'hF, 1'b1, 1'b0, "s3_d2_lz");
        add(58, 4'hF,    4'hF, 1'b1, 1'b0, "s3_d3_lz");
        run_table();
        do_load(16'h0012, 4'b1000);
        add(64, 4'hF,    4'hF, 1'b1, 1'b1, "s3b_fd");
        add(66, 4'b1110, 4'h2, 1'b1, 1'b0, "s3b_d0");
        add(74, 4'b1101, 4'h1, 1'b1, 1'b0, "s3b_d1");
        add(82, 4'b1011, 4'h0, 1'b1, 1'b0, "s3b_d2_lit");
        add(90, 4'b0111, 4'h0, 1'b0, 1'b0, "s3b_d3_dp");
        run_table();

        // Scenario 4: load on the boundary edge keeps the new data for the next frame.
        do_reset();
        run_to(5);
        do_load(16'h1234, 4'b0000);
        run_to(31);
        do_load(16'h5555, 4'b0000);
        chk("s4_fd_first", 4'hF, 4'hF, 1'b1, 1'b1);
        add(33, 4'hF,    4'hF, 1'b1, 1'b0, "s4_fd_gap");
        add(34, 4'b1110, 4'h4, 1'b1, 1'b0, "s4_old_shadow");
        add(58, 4'b0111, 4'h1, 1'b1, 1'b0, "s4_old_d3");
        add(64, 4'hF,    4'hF, 1'b1, 1'b1, "s4_fd_second");
        add(65, 4'hF,    4'hF, 1'b1, 1'b0, "s4_fd_end");
        add(66, 4'b1110, 4'h5, 1'b1, 1'b0, "s4_new_d0");
        run_table();

        // Scenario 5: en low mid-SHOW of idx 2; load while disabled.
        do_reset();
        run_to(19);
        en = 1'b0;
        add(20, 4'hF, 4'hF, 1'b1, 1'b0, "s5_blank_now");
        add(25, 4'hF, 4'hF, 1'b1, 1'b0, "s5_blank_hold");
        run_table();
        do_load(16'h9999, 4'b0000);
        add(39, 4'hF, 4'hF, 1'b1, 1'b0, "s5_blank_end");
        run_table();
        en = 1'b1;
        add(40, 4'hF,    4'hF, 1'b1, 1'b0, "s5_resume_blank");
        add(41, 4'b1011, 4'h0, 1'b1, 1'b0, "s5_resume_d2");
        add(46, 4'b1011, 4'h0, 1'b1, 1'b0, "s5_d2_last");
        add(47, 4'hF,    4'hF, 1'b1, 1'b0, "s5_d3_blank");
        add(49, 4'b0111, 4'h0, 1'b1, 1'b0, "s5_d3_lit");
        add(55, 4'hF,    4'hF, 1'b1, 1'b1, "s5_fd");
        add(57, 4'b1110, 4'h9, 1'b1, 1'b0, "s5_new_d0");
        run_table();

        // Scenario 6: async reset mid-SHOW with a pending load.
        do_reset();
        run_to(3);
        do_load(16'h1234, 4'b0000);
        run_to(20);
        chk("s6_pre_reset", 4'b1011, 4'h0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("s6_async_reset", 4'hF, 4'hF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        add(2,  4'b1110, 4'h0, 1'b1, 1'b0, "s6_first_slot");
        add(18, 4'b1011, 4'h0, 1'b1, 1'b0, "s6_d2");
        add(32, 4'hF,    4'hF, 1'b1, 1'b0, "s6_no_fd");
        add(34, 4'b1110, 4'h0, 1'b1, 1'b0, "s6_still_zero");
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
